// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired CPU sequencer.
//   state_t  : sequencer states (RST, T0..T7, HALT)
//   OP_*     : 5-bit opcode values found in ir[31:27]
//   cls_t    : instruction classes that share one microsequence
//   alu_t    : one-hot ALU operation strobes
//   ctrl_t   : complete control vector produced by control_decode
//   op_class : opcode -> class
//   last_step: class -> final T-state of its microsequence
//   alu_of   : opcode -> ALU strobe for its execute step
package cpu_pkg;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_t;

  typedef struct packed {
    logic AND;
    logic OR;
    logic ADD;
    logic SUB;
    logic MUL;
    logic DIV;
    logic SHR;
    logic SHRA;
    logic SHL;
    logic ROR;
    logic ROL;
    logic NEG;
    logic NOT;
  } alu_t;

  typedef struct packed {
    logic run;
    logic HIout;
    logic LOout;
    logic Zhighout;
    logic Zlowout;
    logic PCout;
    logic MDRout;
    logic INout;
    logic Cout;
    logic MARout;
    logic HIin;
    logic LOin;
    logic PCin;
    logic IRin;
    logic Zin;
    logic Yin;
    logic MARin;
    logic MDRin;
    logic CONin;
    logic OUT_Portin;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic IncPC;
    logic PCSave;
    logic CON_RESET;
    logic Read;
    logic read_mem;
    logic write_mem;
    alu_t alu;
  } ctrl_t;

  function automatic cls_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        return C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:               return C_IMM;
      OP_LDI:                                 return C_LDI;
      OP_LD:                                  return C_LD;
      OP_ST:                                  return C_ST;
      OP_MUL, OP_DIV:                         return C_MULDIV;
      OP_NEG, OP_NOT:                         return C_UNARY;
      OP_BR:                                  return C_BR;
      OP_JR:                                  return C_JR;
      OP_JAL:                                 return C_JAL;
      OP_IN:                                  return C_IN;
      OP_OUT:                                 return C_OUT;
      OP_MFHI:                                return C_MFHI;
      OP_MFLO:                                return C_MFLO;
      OP_HALT:                                return C_HALT;
      default:                                return C_NOP;
    endcase
  endfunction

  function automatic state_t last_step(input cls_t cls);
    case (cls)
      C_RTYPE, C_IMM, C_LDI:         return T5;
      C_LD, C_ST:                    return T7;
      C_MULDIV, C_BR:                return T6;
      C_UNARY, C_JAL:                return T4;
      C_JR, C_IN, C_OUT,
      C_MFHI, C_MFLO:                return T3;
      default:                       return T2;
    endcase
  endfunction

  function automatic alu_t alu_of(input logic [4:0] op);
    alu_t a;
    a = '0;
    case (op)
      OP_ADD, OP_ADDI: a.ADD  = 1'b1;
      OP_SUB:          a.SUB  = 1'b1;
      OP_AND, OP_ANDI: a.AND  = 1'b1;
      OP_OR, OP_ORI:   a.OR   = 1'b1;
      OP_SHR:          a.SHR  = 1'b1;
      OP_SHRA:         a.SHRA = 1'b1;
      OP_SHL:          a.SHL  = 1'b1;
      OP_ROR:          a.ROR  = 1'b1;
      OP_ROL:          a.ROL  = 1'b1;
      OP_MUL:          a.MUL  = 1'b1;
      OP_DIV:          a.DIV  = 1'b1;
      OP_NEG:          a.NEG  = 1'b1;
      OP_NOT:          a.NOT  = 1'b1;
      default:         a      = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-vector decoder (Moore outputs).
//   state  : current sequencer state
//   opcode : ir[31:27]
//   con_ff : branch-condition flip-flop
//   ctrl   : every control strobe for this cycle
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  output ctrl_t      ctrl
);

  cls_t cls;
  alu_t alu;

  always_comb begin
    ctrl = '0;
    cls  = op_class(opcode);
    alu  = alu_of(opcode);
    ctrl.run = (state != RST) && (state != HALT);
    case (state)
      RST: ctrl.CON_RESET = 1'b1;
      T0: begin
        ctrl.IncPC = 1'b1; ctrl.PCin = 1'b1; ctrl.MARin = 1'b1;
      end
      T1: begin
        ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; ctrl.read_mem = 1'b1;
      end
      T2: begin
        ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1;
      end
      T3: begin
        case (cls)
          C_RTYPE, C_IMM: begin
            ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1;
          end
          C_MULDIV: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1;
          end
          C_UNARY: begin
            ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.alu = alu; ctrl.Zin = 1'b1;
          end
          C_BR: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1;
          end
          C_JR: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1;
          end
          C_JAL: begin
            ctrl.PCout = 1'b1; ctrl.PCSave = 1'b1; ctrl.Rin = 1'b1;
          end
          C_IN: begin
            ctrl.INout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          C_OUT: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OUT_Portin = 1'b1;
          end
          C_MFHI: begin
            ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          C_MFLO: begin
            ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_RTYPE: begin
            ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.alu = alu; ctrl.Zin = 1'b1;
          end
          C_IMM: begin
            ctrl.Cout = 1'b1; ctrl.alu = alu; ctrl.Zin = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            ctrl.Cout = 1'b1; ctrl.alu.ADD = 1'b1; ctrl.Zin = 1'b1;
          end
          C_MULDIV: begin
            ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.alu = alu; ctrl.Zin = 1'b1;
          end
          C_UNARY: begin
            ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          C_BR: begin
            ctrl.PCout = 1'b1; ctrl.Yin = 1'b1;
          end
          C_JAL: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_RTYPE, C_IMM, C_LDI: begin
            ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          C_LD, C_ST: begin
            ctrl.Zlowout = 1'b1; ctrl.MARin = 1'b1;
          end
          C_MULDIV: begin
            ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1;
          end
          C_BR: begin
            ctrl.Cout = 1'b1; ctrl.alu.ADD = 1'b1; ctrl.Zin = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_LD: begin
            ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; ctrl.read_mem = 1'b1;
          end
          C_ST: begin
            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1;
          end
          C_MULDIV: begin
            ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1;
          end
          C_BR: begin
            // Branch target only commits when the condition held.
            ctrl.Zlowout = 1'b1; ctrl.PCin = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD: begin
            ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
          end
          C_ST: ctrl.write_mem = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving all CPU datapath control inputs.
//   clk, reset (async, active-low)
//   ir     : current IR; opcode in ir[31:27]
//   con_ff : branch-condition flip-flop
//   stop   : halt request, honoured at the last step of an instruction
//   run    : high in T0..T7
//   remaining outputs: one-cycle datapath control strobes
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        HIout, LOout, Zhighout, Zlowout, PCout,
  output logic        MDRout, INout, Cout, Yout, MARout,
  output logic        HIin, LOin, PCin, IRin, Zin,
  output logic        Yin, MARin, MDRin, CONin, OUT_Portin,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        BAout, IncPC, PCSave, CON_RESET,
  output logic        Read, read_mem, write_mem,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR,
  output logic        SHRA, SHL, ROR, ROL, NEG, NOT,
  output logic        IRout
);

  localparam int unsigned CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  cls_t          cls;
  ctrl_t         ctrl;

  // Only the opcode field steers sequencing.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cls      = op_class(ir[31:27]);
    case (state)
      RST: begin
        if (cnt == CNT_LAST) begin
          state_nx = T0;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      T0: state_nx = T1;
      T1: state_nx = T2;
      T2, T3, T4, T5, T6, T7: begin
        if (state == T2 && cls == C_HALT) begin
          state_nx = HALT;
        end else if (state == last_step(cls)) begin
          state_nx = stop ? HALT : T0;
        end else begin
          case (state)
            T2:      state_nx = T3;
            T3:      state_nx = T4;
            T4:      state_nx = T5;
            T5:      state_nx = T6;
            T6:      state_nx = T7;
            default: state_nx = T0;
          endcase
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = RST;
    endcase
  end

  control_decode u_decode (
    .state  (state),
    .opcode (ir[31:27]),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  always_comb begin
    run        = ctrl.run;
    HIout      = ctrl.HIout;
    LOout      = ctrl.LOout;
    Zhighout   = ctrl.Zhighout;
    Zlowout    = ctrl.Zlowout;
    PCout      = ctrl.PCout;
    MDRout     = ctrl.MDRout;
    INout      = ctrl.INout;
    Cout       = ctrl.Cout;
    Yout       = 1'b0;
    MARout     = ctrl.MARout;
    HIin       = ctrl.HIin;
    LOin       = ctrl.LOin;
    PCin       = ctrl.PCin;
    IRin       = ctrl.IRin;
    Zin        = ctrl.Zin;
    Yin        = ctrl.Yin;
    MARin      = ctrl.MARin;
    MDRin      = ctrl.MDRin;
    CONin      = ctrl.CONin;
    OUT_Portin = ctrl.OUT_Portin;
    Gra        = ctrl.Gra;
    Grb        = ctrl.Grb;
    Grc        = ctrl.Grc;
    Rin        = ctrl.Rin;
    Rout       = ctrl.Rout;
    BAout      = ctrl.BAout;
    IncPC      = ctrl.IncPC;
    PCSave     = ctrl.PCSave;
    CON_RESET  = ctrl.CON_RESET;
    Read       = ctrl.Read;
    read_mem   = ctrl.read_mem;
    write_mem  = ctrl.write_mem;
    AND        = ctrl.alu.AND;
    OR         = ctrl.alu.OR;
    ADD        = ctrl.alu.ADD;
    SUB        = ctrl.alu.SUB;
    MUL        = ctrl.alu.MUL;
    DIV        = ctrl.alu.DIV;
    SHR        = ctrl.alu.SHR;
    SHRA       = ctrl.alu.SHRA;
    SHL        = ctrl.alu.SHL;
    ROR        = ctrl.alu.ROR;
    ROL        = ctrl.alu.ROL;
    NEG        = ctrl.alu.NEG;
    NOT        = ctrl.alu.NOT;
    IRout      = 1'b0;
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-opcode expected strobe
// sequences are listed directly from the instruction microsequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;

  logic run;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Yout, MARout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, PCSave, CON_RESET;
  logic Read, read_mem, write_mem;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic IRout;

  control_unit #(.RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .INout(INout), .Cout(Cout), .Yout(Yout),
    .MARout(MARout), .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin),
    .Zin(Zin), .Yin(Yin), .MARin(MARin), .MDRin(MDRin), .CONin(CONin),
    .OUT_Portin(OUT_Portin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .IncPC(IncPC), .PCSave(PCSave),
    .CON_RESET(CON_RESET), .Read(Read), .read_mem(read_mem),
    .write_mem(write_mem), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB),
    .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR),
    .ROL(ROL), .NEG(NEG), .NOT(NOT), .IRout(IRout)
  );

  always #5 clk = ~clk;

  typedef logic [46:0] vec_t;
  vec_t obs;
  assign obs = {run, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout,
                Cout, Yout, MARout, HIin, LOin, PCin, IRin, Zin, Yin, MARin,
                MDRin, CONin, OUT_Portin, Gra, Grb, Grc, Rin, Rout, BAout,
                IncPC, PCSave, CON_RESET, Read, read_mem, write_mem, AND, OR,
                ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IRout};

  localparam vec_t V_RUN   = vec_t'(1) << 46;
  localparam vec_t V_HIOUT = vec_t'(1) << 45;
  localparam vec_t V_LOOUT = vec_t'(1) << 44;
  localparam vec_t V_ZHI   = vec_t'(1) << 43;
  localparam vec_t V_ZLO   = vec_t'(1) << 42;
  localparam vec_t V_PCOUT = vec_t'(1) << 41;
  localparam vec_t V_MDROUT= vec_t'(1) << 40;
  localparam vec_t V_INOUT = vec_t'(1) << 39;
  localparam vec_t V_COUT  = vec_t'(1) << 38;
  localparam vec_t V_HIIN  = vec_t'(1) << 35;
  localparam vec_t V_LOIN  = vec_t'(1) << 34;
  localparam vec_t V_PCIN  = vec_t'(1) << 33;
  localparam vec_t V_IRIN  = vec_t'(1) << 32;
  localparam vec_t V_ZIN   = vec_t'(1) << 31;
  localparam vec_t V_YIN   = vec_t'(1) << 30;
  localparam vec_t V_MARIN = vec_t'(1) << 29;
  localparam vec_t V_MDRIN = vec_t'(1) << 28;
  localparam vec_t V_CONIN = vec_t'(1) << 27;
  localparam vec_t V_OUTP  = vec_t'(1) << 26;
  localparam vec_t V_GRA   = vec_t'(1) << 25;
  localparam vec_t V_GRB   = vec_t'(1) << 24;
  localparam vec_t V_GRC   = vec_t'(1) << 23;
  localparam vec_t V_RIN   = vec_t'(1) << 22;
  localparam vec_t V_ROUT  = vec_t'(1) << 21;
  localparam vec_t V_BAOUT = vec_t'(1) << 20;
  localparam vec_t V_INCPC = vec_t'(1) << 19;
  localparam vec_t V_PCSAV = vec_t'(1) << 18;
  localparam vec_t V_CONRST= vec_t'(1) << 17;
  localparam vec_t V_READ  = vec_t'(1) << 16;
  localparam vec_t V_RDMEM = vec_t'(1) << 15;
  localparam vec_t V_WRMEM = vec_t'(1) << 14;
  localparam vec_t V_AND   = vec_t'(1) << 13;
  localparam vec_t V_OR    = vec_t'(1) << 12;
  localparam vec_t V_ADD   = vec_t'(1) << 11;
  localparam vec_t V_SUB   = vec_t'(1) << 10;
  localparam vec_t V_MUL   = vec_t'(1) << 9;
  localparam vec_t V_DIV   = vec_t'(1) << 8;
  localparam vec_t V_SHR   = vec_t'(1) << 7;
  localparam vec_t V_SHRA  = vec_t'(1) << 6;
  localparam vec_t V_SHL   = vec_t'(1) << 5;
  localparam vec_t V_ROR   = vec_t'(1) << 4;
  localparam vec_t V_ROL   = vec_t'(1) << 3;
  localparam vec_t V_NEG   = vec_t'(1) << 2;
  localparam vec_t V_NOT   = vec_t'(1) << 1;

  localparam vec_t F0 = V_RUN | V_INCPC | V_PCIN | V_MARIN;
  localparam vec_t F1 = V_RUN | V_READ | V_MDRIN | V_RDMEM;
  localparam vec_t F2 = V_RUN | V_MDROUT | V_IRIN;

  int   compared = 0;
  int   mismatched = 0;
  vec_t exp_seq [0:7];
  vec_t obs_seq [0:7];
  int   exp_len;
  vec_t seen_or;
  int   alu_seen;

  function automatic vec_t alu_for(input logic [4:0] op);
    case (op)
      5'b00011, 5'b01100: return V_ADD;
      5'b00100:           return V_SUB;
      5'b00101, 5'b01101: return V_AND;
      5'b00110, 5'b01110: return V_OR;
      5'b00111:           return V_ROR;
      5'b01000:           return V_ROL;
      5'b01001:           return V_SHR;
      5'b01010:           return V_SHRA;
      5'b01011:           return V_SHL;
      5'b01111:           return V_DIV;
      5'b10000:           return V_MUL;
      5'b10001:           return V_NEG;
      5'b10010:           return V_NOT;
      default:            return '0;
    endcase
  endfunction

  // Reference: full list of strobe sets an instruction produces, fetch included.
  function automatic void build(input logic [4:0] op, input logic c);
    vec_t a;
    a = alu_for(op);
    for (int i = 0; i < 8; i++) exp_seq[i] = '0;
    exp_seq[0] = F0; exp_seq[1] = F1; exp_seq[2] = F2;
    exp_len = 3;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
        exp_seq[3] = V_RUN | V_GRB | V_ROUT | V_YIN;
        exp_seq[4] = V_RUN | V_GRC | V_ROUT | a | V_ZIN;
        exp_seq[5] = V_RUN | V_ZLO | V_GRA | V_RIN;
        exp_len = 6;
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_seq[3] = V_RUN | V_GRB | V_ROUT | V_YIN;
        exp_seq[4] = V_RUN | V_COUT | a | V_ZIN;
        exp_seq[5] = V_RUN | V_ZLO | V_GRA | V_RIN;
        exp_len = 6;
      end
      5'b00001, 5'b00000, 5'b00010: begin
        exp_seq[3] = V_RUN | V_GRB | V_BAOUT | V_YIN;
        exp_seq[4] = V_RUN | V_COUT | V_ADD | V_ZIN;
        if (op == 5'b00001) begin
          exp_seq[5] = V_RUN | V_ZLO | V_GRA | V_RIN;
          exp_len = 6;
        end else begin
          exp_seq[5] = V_RUN | V_ZLO | V_MARIN;
          if (op == 5'b00000) begin
            exp_seq[6] = V_RUN | V_READ | V_MDRIN | V_RDMEM;
            exp_seq[7] = V_RUN | V_MDROUT | V_GRA | V_RIN;
          end else begin
            exp_seq[6] = V_RUN | V_GRA | V_ROUT | V_MDRIN;
            exp_seq[7] = V_RUN | V_WRMEM;
          end
          exp_len = 8;
        end
      end
      5'b10000, 5'b01111: begin
        exp_seq[3] = V_RUN | V_GRA | V_ROUT | V_YIN;
        exp_seq[4] = V_RUN | V_GRB | V_ROUT | a | V_ZIN;
        exp_seq[5] = V_RUN | V_ZLO | V_LOIN;
        exp_seq[6] = V_RUN | V_ZHI | V_HIIN;
        exp_len = 7;
      end
      5'b10001, 5'b10010: begin
        exp_seq[3] = V_RUN | V_GRB | V_ROUT | a | V_ZIN;
        exp_seq[4] = V_RUN | V_ZLO | V_GRA | V_RIN;
        exp_len = 5;
      end
      5'b10011: begin
        exp_seq[3] = V_RUN | V_GRA | V_ROUT | V_CONIN;
        exp_seq[4] = V_RUN | V_PCOUT | V_YIN;
        exp_seq[5] = V_RUN | V_COUT | V_ADD | V_ZIN;
        exp_seq[6] = V_RUN | V_ZLO | (c ? V_PCIN : vec_t'(0));
        exp_len = 7;
      end
      5'b10100: begin exp_seq[3] = V_RUN | V_GRA | V_ROUT | V_PCIN; exp_len = 4; end
      5'b10101: begin
        exp_seq[3] = V_RUN | V_PCOUT | V_PCSAV | V_RIN;
        exp_seq[4] = V_RUN | V_GRA | V_ROUT | V_PCIN;
        exp_len = 5;
      end
      5'b10110: begin exp_seq[3] = V_RUN | V_INOUT | V_GRA | V_RIN; exp_len = 4; end
      5'b10111: begin exp_seq[3] = V_RUN | V_GRA | V_ROUT | V_OUTP; exp_len = 4; end
      5'b11001: begin exp_seq[3] = V_RUN | V_HIOUT | V_GRA | V_RIN; exp_len = 4; end
      5'b11000: begin exp_seq[3] = V_RUN | V_LOOUT | V_GRA | V_RIN; exp_len = 4; end
      default: exp_len = 3;
    endcase
  endfunction

  // Starts #1 after the edge that entered T0; ends #1 after the edge
  // that leaves the instruction's last step.
  task automatic run_instr(input logic [31:0] instr, input logic c,
                           input logic stop_end, input string tag);
    ir = instr;
    con_ff = c;
    build(instr[31:27], c);
    seen_or = '0;
    alu_seen = 0;
    for (int i = 0; i < exp_len; i++) begin
      @(negedge clk);
      obs_seq[i] = obs;
      compared++;
      if (obs !== exp_seq[i]) begin
        mismatched++;
        $display("FAIL %s op=%b step T%0d: got %h expected %h",
                 tag, instr[31:27], i, obs, exp_seq[i]);
      end
      seen_or |= obs;
      alu_seen += $countones(obs[13:1]);
      stop = (i == exp_len - 1) ? stop_end : ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    stop = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      compared++;
      if (obs !== V_CONRST) begin
        mismatched++;
        $display("FAIL reset_held: got %h expected %h", obs, V_CONRST);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== V_CONRST) begin
        mismatched++;
        $display("FAIL rst_cycle%0d: got %h expected %h", i, obs, V_CONRST);
      end
      @(posedge clk);
      #1;
    end
    compared++;
    if (obs !== F0) begin
      mismatched++;
      $display("FAIL rst_to_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_addi();
    run_instr(32'h61880005, 1'b0, 1'b0, "addi");
    compared++;
    if (obs !== F0) begin
      mismatched++;
      $display("FAIL addi_back_to_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_ld();
    run_instr(32'h00800075, 1'b0, 1'b0, "ld");
    // Ninth cycle must already be the next fetch.
    compared++;
    if (obs !== F0) begin
      mismatched++;
      $display("FAIL ld_8_cycles: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_st();
    run_instr({5'b00010, 27'($urandom)}, 1'b0, 1'b0, "st");
    compared++;
    if ((seen_or & V_RIN) !== '0) begin
      mismatched++;
      $display("FAIL st_no_rin: got Rin seen=%0b expected 0", |(seen_or & V_RIN));
    end
    compared++;
    if (obs_seq[7] !== (V_RUN | V_WRMEM)) begin
      mismatched++;
      $display("FAIL st_t7: got %h expected %h", obs_seq[7], V_RUN | V_WRMEM);
    end
  endtask

  task automatic test_br();
    for (int k = 0; k < 2; k++) begin
      run_instr({5'b10011, 27'($urandom)}, k[0], 1'b0, "br");
      compared++;
      if (obs_seq[6][33] !== k[0]) begin
        mismatched++;
        $display("FAIL br_pcin con=%0d: got %b expected %b", k, obs_seq[6][33], k[0]);
      end
    end
  endtask

  task automatic test_mul();
    run_instr({5'b10000, 27'($urandom)}, 1'b1, 1'b0, "mul");
    compared++;
    if (alu_seen !== 1 || (seen_or & V_MUL) !== V_MUL) begin
      mismatched++;
      $display("FAIL mul_one_alu: got %0d alu strobes expected 1 (MUL)", alu_seen);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr({op, 27'($urandom)}, 1'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_halt();
    run_instr({5'b11011, 27'($urandom)}, 1'b0, 1'b0, "halt");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stop = 1'($urandom);
      compared++;
      if (obs !== '0) begin
        mismatched++;
        $display("FAIL halt_quiet cyc%0d: got %h expected 0", i, obs);
      end
    end
    stop = 1'b0;
    apply_reset();
  endtask

  task automatic test_stop();
    run_instr({5'b00100, 27'($urandom)}, 1'b0, 1'b1, "stop");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== '0) begin
        mismatched++;
        $display("FAIL stop_halted cyc%0d: got %h expected 0", i, obs);
      end
    end
    apply_reset();
    compared++;
    if (obs !== F0) begin
      mismatched++;
      $display("FAIL stop_reset_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_midreset();
    ir = {5'b00011, 27'($urandom)};
    build(5'b00011, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_seq[i]) begin
        mismatched++;
        $display("FAIL midreset_pre T%0d: got %h expected %h", i, obs, exp_seq[i]);
      end
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    #1 reset = 1'b0;
    #1;
    compared++;
    if (obs !== V_CONRST) begin
      mismatched++;
      $display("FAIL midreset_clear: got %h expected %h", obs, V_CONRST);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== V_CONRST) begin
        mismatched++;
        $display("FAIL midreset_rst%0d: got %h expected %h", i, obs, V_CONRST);
      end
      @(posedge clk);
      #1;
    end
    compared++;
    if (obs !== F0) begin
      mismatched++;
      $display("FAIL midreset_t0: got %h expected %h", obs, F0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_ld();
    test_st();
    test_br();
    test_mul();
    test_random();
    test_midreset();
    test_stop();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore sequencer that drives every control input of the `CPU` datapath in place of a hand-written stimulus FSM.
- Fetches an instruction, decodes `IR[31:27]`, and steps through the per-class T-state microsequence, asserting each control strobe for exactly one clock.
- Sits beside `CPU` in the top level: receives IR and CON flip-flop status, returns all control strobes.

Parameters:
- `RESET_CYCLES`, 2: cycles held in `RST` state after reset deassertion, with `CON_RESET` high.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `ir`  in  32  current IR contents; opcode in `ir[31:27]`.
- `con_ff`  in  1  branch-condition flip-flop output.
- `stop`  in  1  level request to halt at the next instruction boundary.
- `run`  out  1  high while executing; low in `RST` and `HALT`.
- Bus-source strobes, out, 1 each: `HIout` `LOout` `Zhighout` `Zlowout` `PCout` `MDRout` `INout` `Cout` `Yout` `MARout`.
- Register-load strobes, out, 1 each: `HIin` `LOin` `PCin` `IRin` `Zin` `Yin` `MARin` `MDRin` `CONin` `OUT_Portin`.
- Register-select and control, out, 1 each: `Gra` `Grb` `Grc` `Rin` `Rout` `BAout` `IncPC` `PCSave` `CON_RESET`.
- Memory strobes, out, 1 each: `Read` `read_mem` `write_mem`.
- ALU ops, out, 1 each: `AND` `OR` `ADD` `SUB` `MUL` `DIV` `SHR` `SHRA` `SHL` `ROR` `ROL` `NEG` `NOT`.
- `IRout` and `Yout`: tied 0.

Behaviour:
- States: `RST`, `T0`–`T7`, `HALT`.
- While `reset` = 0, asynchronously: state = `RST`, counter cleared, every output 0 except `CON_RESET` = 1.
- `RST` holds for `RESET_CYCLES` cycles, then goes to `T0`.
- Reset asserted mid-sequence aborts immediately; no partial strobes leak.
- Outputs are combinational from (state, opcode, `con_ff`) only, Moore style, and never depend on `stop`.
- Each strobe is high for one full cycle.
- Fetch, all opcodes:
  - `T0`: `IncPC` `PCin` `MARin`.
  - `T1`: `Read` `MDRin` `read_mem`.
  - `T2`: `MDRout` `IRin`.
- Decode uses `ir` from `T3` onward, after IR has loaded at the end of `T2`.
- Per-class execution, entered from `T2`:
  - R-type (add sub and or shr shra shl ror rol):
    - `T3`: `Grb` `Rout` `Yin`.
    - `T4`: `Grc` `Rout` op `Zin`.
    - `T5`: `Zlowout` `Gra` `Rin`.
  - addi, andi, ori: as R-type, except `T4` uses `Cout` instead of `Grc`/`Rout`; op is ADD, AND or OR.
  - ldi:
    - `T3`: `Grb` `BAout` `Yin`.
    - `T4`: `Cout` `ADD` `Zin`.
    - `T5`: `Zlowout` `Gra` `Rin`.
  - ld:
    - `T3`–`T4`: as ldi.
    - `T5`: `Zlowout` `MARin`.
    - `T6`: `Read` `MDRin` `read_mem`.
    - `T7`: `MDRout` `Gra` `Rin`.
  - st:
    - `T3`–`T5`: as ld.
    - `T6`: `Gra` `Rout` `MDRin`.
    - `T7`: `write_mem`.
  - mul, div:
    - `T3`: `Gra` `Rout` `Yin`.
    - `T4`: `Grb` `Rout` op `Zin`.
    - `T5`: `Zlowout` `LOin`.
    - `T6`: `Zhighout` `HIin`.
  - neg, not:
    - `T3`: `Grb` `Rout` op `Zin`.
    - `T4`: `Zlowout` `Gra` `Rin`.
  - br:
    - `T3`: `Gra` `Rout` `CONin`.
    - `T4`: `PCout` `Yin`.
    - `T5`: `Cout` `ADD` `Zin`.
    - `T6`: `Zlowout`, plus `PCin` only if `con_ff` = 1.
  - jr: `T3`: `Gra` `Rout` `PCin`.
  - jal:
    - `T3`: `PCout` `PCSave` `Rin`.
    - `T4`: `Gra` `Rout` `PCin`.
  - in: `T3`: `INout` `Gra` `Rin`.
  - out: `T3`: `Gra` `Rout` `OUT_Portin`.
  - mfhi: `T3`: `HIout` `Gra` `Rin`.
  - mflo: `T3`: `LOout` `Gra` `Rin`.
  - nop, and any undefined opcode: return to `T0` after `T2`.
  - halt: `T2` → `HALT`.
- The last step of each class returns to `T0`, unless `stop` = 1 on that edge, in which case it goes to `HALT`.
- `HALT`: all strobes 0, `run` = 0; the state is left only by reset.
- `run` = 1 in `T0`–`T7`.

Decomposition:
- Package `cpu_pkg` holds:
  - state enum;
  - 5-bit opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011;
  - a last-step table (opcode class → final T-state).
- One sub-module, `control_decode`: purely combinational, (state, opcode, `con_ff`) → control vector.
- `control_unit` keeps the state register, reset counter and next-state logic.

Test Plan:
- Reset release, then ir = 0x61880005 (addi r3,r1,5):
  - `RST` lasts 2 cycles with `CON_RESET` = 1;
  - `T3` asserts `Grb` `Rout` `Yin`;
  - `T4` asserts `Cout` `ADD` `Zin`;
  - `T5` asserts `Zlowout` `Gra` `Rin`;
  - then `T0`.
- ld (ir = 0x00800075): `T6` asserts `read_mem` `MDRin`, `T7` asserts `MDRout` `Rin`; instruction takes 8 cycles total.
- st: `T7` asserts `write_mem` alone; no `Rin` occurs anywhere in the sequence.
- br with `con_ff` = 0: no `PCin` in `T6`. Repeat with `con_ff` = 1: `PCin` = 1 in `T6`.
- mul:
  - `T5` asserts `LOin` only;
  - `T6` asserts `HIin` only;
  - exactly one ALU op strobe (`MUL`) is seen across the sequence.
- Two cases:
  - halt opcode: → `HALT` after `T2`, `run` = 0, strobes stay 0 for 10 cycles;
  - `reset` low during `T4` of add: outputs clear the same cycle and state restarts at `RST`.
